sram_song_loader: RTL
=====================

Name: sram_song_loader

Overview:
- Write-side counterpart of the player's SRAM instruction fetch. Accepts a byte stream of song instructions from a host link (e.g. UART receiver) and packs byte pairs into 16-bit words, low byte first.
- Writes the words to the external async SRAM at consecutive addresses from 0.
- Signals completion so the player can begin fetching from address 0.
- Owns the SRAM bus only while load_busy is high; the top level muxes the bus and the tristate.

Parameters:
- WE_CYCLES, 3: clk cycles sram_WE is held low per write (60 ns at 50 MHz). Legal range 1..15.
- END_WORD, 16'hFFFF: terminator word. It is written to SRAM, then the load completes.
- MAX_ADDR, 18'h3FFFF: last writable address.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle pulse; begins a new load at address 0
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  incoming byte
- byte_ready  out  1  loader accepts a byte this cycle (transfer = byte_valid & byte_ready)
- sram_WE  out  1  active-low write enable
- sram_CE  out  1  active-low chip enable
- sram_OE  out  1  active-low output enable
- sram_LB  out  1  active-low lower-byte enable
- sram_UB  out  1  active-low upper-byte enable
- sram_addr  out  18  SRAM address
- sram_dout  out  16  write data to the top-level tristate
- sram_drive  out  1  1 = top level drives sram_io with sram_dout
- load_busy  out  1  loader owns the SRAM bus
- load_done  out  1  sticky; set on terminator write, cleared by load_start
- load_overflow  out  1  sticky; set when a write lands at MAX_ADDR without the terminator, cleared by load_start
- word_count  out  18  words written in the current load, including the terminator

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE; sram_WE=1, sram_CE=1, sram_OE=1, sram_LB=1, sram_UB=1.
- sram_addr=0, sram_dout=0, sram_drive=0, byte_ready=0, load_busy=0, load_done=0, load_overflow=0, word_count=0.
- Reset during a write cycle deasserts sram_WE immediately (asynchronously). The partial word is lost.

States:
- IDLE: byte_ready=0; bytes are ignored. On load_start: clear addr, word_count, load_done and load_overflow, then go to LO.
- LO: byte_ready=1, load_busy=1, CE=0, LB=0, UB=0, OE=1. On transfer: latch byte_data into dout[7:0], then go to HI.
- HI: byte_ready=1. On transfer: latch byte_data into dout[15:8], then go to SETUP.
- SETUP (1 cycle): sram_drive=1, WE=1; addr and dout are stable. Go to WRITE.
- WRITE (WE_CYCLES cycles): WE=0, drive=1. A 4-bit counter times the pulse. Then go to HOLD.
- HOLD (1 cycle): WE=1, drive=1, data held. word_count increments. Then:
  - if dout==END_WORD: set load_done, go to IDLE;
  - else if addr==MAX_ADDR: set load_overflow, go to IDLE;
  - else addr increments by 1, go to LO.

Timing and rules:
- byte_ready is 0 in SETUP, WRITE, HOLD and IDLE. Throughput is one word per WE_CYCLES+4 cycles minimum.
- In IDLE, load_busy=0 and all SRAM controls are inactive (1). sram_addr holds its last value.
- sram_addr and sram_dout never change while WE=0. sram_drive is 1 only in SETUP, WRITE and HOLD.
- load_start outside IDLE is ignored. The host must wait for load_busy=0.
- A load_start pulse and byte_valid in the same IDLE cycle: the byte is not accepted.
- word_count saturates at 2^18-1. The address never wraps past MAX_ADDR.
- The terminator check compares the full 16-bit word. An END_WORD written at MAX_ADDR sets load_done, not load_overflow.

Test Plan:
1. Reset → load_start → bytes 34,12,CD,AB,FF,FF, each with byte_valid. Required:
   - writes 0x1234@0, 0xABCD@1, 0xFFFF@2, each with a WE low pulse of exactly 3 cycles;
   - load_done=1, word_count=3, load_busy=0.
2. Throttled source: byte_valid high only 1 cycle in 7, random gaps. Required: identical SRAM contents to scenario 1; no WE pulse until both bytes of a word have been transferred.
3. MAX_ADDR=18'h3 override, 5 non-terminator words. Required:
   - 4 writes at addresses 0..3;
   - load_overflow=1, load_done=0, byte_ready=0 afterwards;
   - the 5th word is not written.
4. rst_n asserted during the 2nd WRITE cycle of word 1. Required:
   - sram_WE=1 in the same cycle (asynchronous);
   - all outputs at reset values;
   - a later load restarts at address 0.
5. Second load_start after done. Required: load_done cleared, word_count=0, the first write lands at address 0. A load_start pulse mid-load (in state HI) is ignored with no address change.
6. Bus protocol check every cycle. Required:
   - sram_addr and sram_dout are constant whenever sram_WE=0;
   - sram_OE=1 throughout any load;
   - sram_drive=0 in IDLE, LO and HI.

Source files
------------

// File: rtl/sram_song_loader.sv
// Song loader: packs a host byte stream (low byte first) into 16-bit words and
// writes them to the external async SRAM from address 0 until the terminator word.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | bus released, bytes ignored, waiting for load_start
// S_LO    | bus owned, waiting for low byte of the next word
// S_HI    | waiting for high byte
// S_SETUP | address/data driven, WE still high (setup time)
// S_WRITE | WE low for WE_CYCLES clocks, timed by a down-counter
// S_HOLD  | WE high, data held; count the word and pick next address or finish
module sram_song_loader #(
   parameter int unsigned WE_CYCLES = 3,
   parameter logic [15:0] END_WORD  = 16'hFFFF,
   parameter logic [17:0] MAX_ADDR  = 18'h3FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        sram_WE,
   output logic        sram_CE,
   output logic        sram_OE,
   output logic        sram_LB,
   output logic        sram_UB,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dout,
   output logic        sram_drive,
   output logic        load_busy,
   output logic        load_done,
   output logic        load_overflow,
   output logic [17:0] word_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LO, S_HI, S_SETUP, S_WRITE, S_HOLD
   } state_t;

   localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  we_cnt_q;
   logic [17:0] addr_q, addr_d;
   logic [15:0] dout_q;
   logic [17:0] word_count_q, word_count_d;
   logic        we_n_q, busy_q, drive_q, ready_q, done_q, ovf_q;
   logic        xfer;

   assign xfer         = byte_valid & ready_q;
   assign addr_d       = addr_q + 18'd1;
   assign word_count_d = (word_count_q == '1) ? word_count_q : word_count_q + 18'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         we_cnt_q     <= '0;
         addr_q       <= '0;
         dout_q       <= '0;
         word_count_q <= '0;
         we_n_q       <= 1'b1;
         busy_q       <= 1'b0;
         drive_q      <= 1'b0;
         ready_q      <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load_start) begin
                  addr_q       <= '0;
                  word_count_q <= '0;
                  done_q       <= 1'b0;
                  ovf_q        <= 1'b0;
                  busy_q       <= 1'b1;
                  ready_q      <= 1'b1;
                  state_q      <= S_LO;
               end
            end
            S_LO: begin
               if (xfer) begin
                  dout_q[7:0] <= byte_data;
                  state_q     <= S_HI;
               end
            end
            S_HI: begin
               if (xfer) begin
                  dout_q[15:8] <= byte_data;
                  ready_q      <= 1'b0;
                  drive_q      <= 1'b1;
                  state_q      <= S_SETUP;
               end
            end
            S_SETUP: begin
               we_n_q   <= 1'b0;
               we_cnt_q <= WE_LOAD;
               state_q  <= S_WRITE;
            end
            S_WRITE: begin
               if (we_cnt_q == 4'd0) begin
                  we_n_q  <= 1'b1;
                  state_q <= S_HOLD;
               end else begin
                  we_cnt_q <= we_cnt_q - 4'd1;
               end
            end
            S_HOLD: begin
               word_count_q <= word_count_d;
               drive_q      <= 1'b0;
               // Terminator wins over overflow when both land on the last address
               if (dout_q == END_WORD) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (addr_q == MAX_ADDR) begin
                  ovf_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  addr_q  <= addr_d;
                  ready_q <= 1'b1;
                  state_q <= S_LO;
               end
            end
            default: begin
               we_n_q  <= 1'b1;
               busy_q  <= 1'b0;
               drive_q <= 1'b0;
               ready_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Chip and byte enables follow bus ownership; reads never happen here
   assign sram_CE       = ~busy_q;
   assign sram_LB       = ~busy_q;
   assign sram_UB       = ~busy_q;
   assign sram_OE       = 1'b1;
   assign sram_WE       = we_n_q;
   assign sram_addr     = addr_q;
   assign sram_dout     = dout_q;
   assign sram_drive    = drive_q;
   assign byte_ready    = ready_q;
   assign load_busy     = busy_q;
   assign load_done     = done_q;
   assign load_overflow = ovf_q;
   assign word_count    = word_count_q;

endmodule
